// File: rtl/countdown_timer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// countdown_timer_if - switch inputs and display/status outputs of the timer
// Rev 1.0
// ---------------------------------------------------------------------------
interface countdown_timer_if;
  logic       Load;
  logic       Enable;
  logic [7:0] Preset;
  logic [0:6] HEX1;
  logic [0:6] HEX0;
  logic       Tick;
  logic       Done;

  modport slave  (input Load, Enable, Preset, output HEX1, HEX0, Tick, Done);
  modport master (output Load, Enable, Preset, input HEX1, HEX0, Tick, Done);
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// countdown_timer - two-digit BCD countdown with prescaler and 7-seg outputs
// Rev 1.0
// ---------------------------------------------------------------------------
module countdown_timer #(
  parameter int TICKS = 50_000_000
) (
  input  logic             CLOCK_50,
  input  logic             Clear,
  countdown_timer_if.slave bus
);
  localparam int               PRE_W   = $clog2(TICKS);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [3:0]       tens, tens_next;
  logic [3:0]       ones, ones_next;
  logic [PRE_W-1:0] pre, pre_next;
  logic             tick, tick_next;
  logic             count_zero;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [0:6] seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  assign count_zero = (tens == 4'd0) && (ones == 4'd0);

  always_comb begin
    state_next = state;
    tens_next  = tens;
    ones_next  = ones;
    pre_next   = pre;
    tick_next  = 1'b0;
    if (bus.Load) begin
      tens_next  = clamp9(bus.Preset[7:4]);
      ones_next  = clamp9(bus.Preset[3:0]);
      pre_next   = '0;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          pre_next = '0;
          if (bus.Enable && !count_zero) state_next = RUN;
        end
        RUN: begin
          // Enable low is a pause: prescaler and count both hold.
          if (bus.Enable) begin
            if (pre == PRE_MAX) begin
              pre_next  = '0;
              tick_next = 1'b1;
              if (ones != 4'd0) begin
                ones_next = ones - 4'd1;
              end else begin
                ones_next = 4'd9;
                tens_next = tens - 4'd1;
              end
              if ((tens == 4'd0) && (ones == 4'd1)) state_next = DONE;
            end else begin
              pre_next = pre + 1'b1;
            end
          end
        end
        DONE: begin
          tens_next = 4'd0;
          ones_next = 4'd0;
          pre_next  = '0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Clear) begin
      state <= IDLE;
      tens  <= 4'd0;
      ones  <= 4'd0;
      pre   <= '0;
      tick  <= 1'b0;
    end else begin
      state <= state_next;
      tens  <= tens_next;
      ones  <= ones_next;
      pre   <= pre_next;
      tick  <= tick_next;
    end
  end

  assign bus.HEX1 = seg(tens);
  assign bus.HEX0 = seg(ones);
  assign bus.Tick = tick;
  assign bus.Done = (state == DONE);
endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_countdown_timer - vector table plus scoreboard bench for countdown_timer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_countdown_timer;
  localparam int TICKS = 4;

  logic clk = 1'b0;
  logic clear;

  countdown_timer_if bus();

  countdown_timer #(.TICKS(TICKS)) dut (
    .CLOCK_50 (clk),
    .Clear    (clear),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       ld;
    logic       en;
    logic [7:0] preset;
    int         cnt;
    logic       tick;
    logic       done;
  } vec_t;

  typedef struct {
    int   cnt;
    logic tick;
    logic done;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] seg_ref [10];

  task automatic check(input string what, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", what, act, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input logic c, input logic l, input logic e, input logic [7:0] p,
                      input int cnt, input logic t, input logic d, input string tag);
    exp_t x;
    clear      = c;
    bus.Load   = l;
    bus.Enable = e;
    bus.Preset = p;
    x.cnt  = cnt;
    x.tick = t;
    x.done = d;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({tag, " HEX1"}, bus.HEX1, seg_ref[x.cnt / 10]);
    check({tag, " HEX0"}, bus.HEX0, seg_ref[x.cnt % 10]);
    check({tag, " Tick"}, {6'd0, bus.Tick}, {6'd0, x.tick});
    check({tag, " Done"}, {6'd0, bus.Done}, {6'd0, x.done});
  endtask

  function automatic void add(input logic c, input logic l, input logic e, input logic [7:0] p,
                              input int cnt, input logic t, input logic d);
    vec_t v;
    v.clr = c; v.ld = l; v.en = e; v.preset = p;
    v.cnt = cnt; v.tick = t; v.done = d;
    vecs.push_back(v);
  endfunction

  task automatic add_run(input int n, input int cnt);
    for (int i = 0; i < n; i++) add(0, 0, 1, 8'h00, cnt, 0, 0);
  endtask

  initial begin
    logic [31:0] r;
    seg_ref = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    clear      = 1'b1;
    bus.Load   = 1'b0;
    bus.Enable = 1'b0;
    bus.Preset = 8'h00;

    // Clamp to 99, then a zero preset that must never start.
    add(0, 1, 0, 8'hAF, 99, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 8'h00, 0, 0, 0);
    // Pause: two running cycles, ten paused, then two more to the first step.
    add(0, 1, 0, 8'h05, 5, 0, 0);
    add_run(3, 5);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 8'h00, 5, 0, 0);
    add_run(1, 5);
    add(0, 0, 1, 8'h00, 4, 1, 0);
    add(0, 0, 0, 8'h00, 4, 0, 0);
    // Load+Enable, then Load on a terminal prescaler cycle, then full period.
    add(0, 1, 1, 8'h37, 37, 0, 0);
    add_run(4, 37);
    add(0, 1, 1, 8'h25, 25, 0, 0);
    add_run(4, 25);
    add(0, 0, 1, 8'h00, 24, 1, 0);
    add(1, 1, 1, 8'h58, 0, 0, 0);
    // Reach DONE, Enable ignored, Load leaves it.
    add(0, 1, 0, 8'h01, 1, 0, 0);
    add_run(4, 1);
    add(0, 0, 1, 8'h00, 0, 1, 1);
    for (int i = 0; i < 2; i++) add(0, 0, 1, 8'h00, 0, 0, 1);
    add(0, 1, 1, 8'h03, 3, 0, 0);
    add(0, 0, 0, 8'h00, 3, 0, 0);
    // Reach DONE again, Clear leaves it.
    add(0, 1, 0, 8'h01, 1, 0, 0);
    add_run(4, 1);
    add(0, 0, 1, 8'h00, 0, 1, 1);
    add(1, 0, 1, 8'h00, 0, 0, 0);

    for (int i = 0; i < 2; i++) begin
      r = $urandom();
      step(1, r[0], r[1], r[15:8], 0, 0, 0, "reset");
    end

    step(0, 1, 0, 8'h12, 12, 0, 0, "load12");
    step(0, 0, 1, 8'h00, 12, 0, 0, "start12");
    for (int k = 1; k <= 12; k++) begin
      for (int j = 0; j < TICKS - 1; j++)
        step(0, 0, 1, 8'h00, 13 - k, 0, 0, $sformatf("cd%0d_wait", k));
      step(0, 0, 1, 8'h00, 12 - k, 1, (k == 12), $sformatf("cd%0d_dec", k));
    end
    for (int j = 0; j < 3; j++) step(0, 0, 1, 8'h00, 0, 0, 1, "cd_hold");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].preset,
           vecs[i].cnt, vecs[i].tick, vecs[i].done, $sformatf("vec%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/countdown_timer.md
# countdown_timer

Two-digit BCD countdown timer for the 50 MHz board clock. The complement of the lab's 0–9 up-counter: it loads a preset from the switches and counts down to 00 at 1 s intervals, using an internal prescaler. It drives two active-low seven-segment digits and raises a sticky `Done` flag on expiry. It sits at the top level between the switch inputs and the HEX1/HEX0 displays.

## Interface
- `TICKS`, default 50_000_000: clock cycles per count step. Must be ≥ 2. Benches override it with a small value.
- `CLOCK_50` in 1: system clock. Every register updates on its rising edge.
- `Clear` in 1: synchronous, active-high reset. Highest priority.
- `Load` in 1: load `Preset` into the count. Priority over `Enable`.
- `Enable` in 1: high = run; low = pause.
- `Preset` in 8: `[7:4]` is the tens BCD digit, `[3:0]` is the ones BCD digit.
- `HEX1` out [0:6]: tens digit, segments a..g, active-low.
- `HEX0` out [0:6]: ones digit, segments a..g, active-low.
- `Tick` out 1: one-cycle pulse, high in the cycle the count decrements.
- `Done` out 1: high while in DONE.

## Operation
- Registers:
  - `tens`, `ones`: 4 bits each, BCD.
  - `pre`: prescaler, `$clog2(TICKS)` bits.
  - `state`: one of IDLE, RUN, DONE.
  - `Tick`, registered.
- Clear (any state): `tens`=0, `ones`=0, `pre`=0, `state`=IDLE, `Tick`=0, `Done`=0. HEX1/HEX0 then display "00".
- Load (not Clear, any state):
  - Digits are loaded from `Preset`.
  - Any digit greater than 9 is clamped to 9.
  - `pre`=0, `state`=IDLE, `Tick`=0.
- IDLE:
  - If `Enable`=1 and the count ≠ 00, go to RUN. `pre` stays 0 on this transition cycle.
  - If the count is 00, stay in IDLE regardless of `Enable`.
- RUN:
  - `Enable`=0 freezes `pre` and the count. The state stays RUN (pause).
  - `Enable`=1 and `pre` < TICKS−1: `pre` increments.
  - `Enable`=1 and `pre` = TICKS−1: `pre`=0, `Tick`=1 next cycle, and the count decrements in BCD:
    - ones ≠ 0: ones−1.
    - ones = 0: ones=9, tens−1.
  - If the decrement produces 00, go to DONE in the same edge.
- DONE:
  - Count is held at 00. `Done`=1. `pre` is held at 0.
  - Only Clear or Load leaves DONE. `Enable` is ignored.
- `Tick` is 0 in every cycle other than the one after a decrement edge.
- Seven-segment decode is combinational from `tens`/`ones`. Active-low a..g patterns:
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001111
  - 8 = 0000000
  - 9 = 0000100
  - Unreachable codes: 1111111 (blank).
- Decrement never underflows, because the count 00 is never decremented.

## Timing
- Reset values:
  - HEX1 = HEX0 = 0000001.
  - `Tick` = 0, `Done` = 0.
- Load-to-display latency: 1 cycle. The edge that samples Load updates the digits, and HEX updates combinationally in the same cycle.
- Start-up: the edge that samples `Enable` in IDLE enters RUN. With `Enable` held high, the first decrement occurs at the TICKS-th edge after RUN is entered. Later decrements occur every TICKS edges.
- Pause: every cycle with `Enable` low in RUN delays the next decrement by exactly one cycle. No partial period is lost.
- `Tick` goes high in the same cycle the new count becomes visible.
- On the final decrement to 00, `Done` and `Tick` assert together, and `Tick` clears next cycle.
- Simultaneous inputs:
  - Clear+Load: Clear wins.
  - Load+Enable: Load wins; the next `Enable` edge starts the run.
  - Load coincident with a terminal prescaler edge: Load wins; no decrement, `Tick`=0.
- Clear or Load mid-RUN discards `pre`. The next run takes a full TICKS period to its first decrement.

## Test plan
- Reset: assert Clear for 2 cycles with random inputs → HEX1=HEX0=0000001, `Tick`=0, `Done`=0.
- Basic countdown (TICKS=4):
  - Stimulus: Load `Preset`=0x12, then hold `Enable` high.
  - Expected display sequence: 12, 11, 10, 09, …, 01, 00, one step every 4 cycles.
  - `Tick` is a single-cycle pulse at each step.
  - `Done`=1 from the 00 step onward.
  - 10→09 checks the tens borrow: HEX1 shows 0000001 and HEX0 shows 0000100.
- Pause (TICKS=4): Load 0x05, `Enable`=1 for 2 RUN cycles, 0 for 10 cycles, then 1 → first decrement to 04 after exactly 2 more `Enable`-high cycles.
- Clamp and zero:
  - Load 0xAF → display 99.
  - Load 0x00, then `Enable`=1 → stays IDLE, no `Tick`, `Done`=0.
- Priority:
  - Load with `Enable` on a terminal prescaler cycle → count equals the new Preset, `Tick`=0.
  - Clear+Load together → display 00.
  - In DONE, Load 0x03 → `Done`=0 next cycle, display 03.
